// File: rtl/nim_pkg.sv
// -----------------------------------------------------------------------------
// nim_pkg
// Shared definitions for the pile-game sequencer:
//   - default board geometry (NUM_PILES_DEF, PILE_W_DEF) and status width
//   - page encodings seen by the display, plus the internal FSM states
//   - pile_extract(): read one pile out of a packed board
//   - page_of(): maps an internal state onto the page it displays
// -----------------------------------------------------------------------------
package nim_pkg;

    localparam int NUM_PILES_DEF = 10;
    localparam int PILE_W_DEF    = 4;
    localparam int STATUS_W      = 3;

    // Upper bounds for pile_extract; any legal board geometry must fit these.
    localparam int MAX_PILE_W    = 8;
    localparam int MAX_BOARD_W   = 256;
    localparam int MAX_BOARD_AW  = 8;

    typedef enum logic [STATUS_W-1:0] {
        PAGE_START  = 3'd0,
        PAGE_HELP   = 3'd1,
        PAGE_SELECT = 3'd2,
        PAGE_PLAY   = 3'd3,
        PAGE_RESULT = 3'd4
    } page_e;

    // ST_GAP is the one-cycle pause between rounds; it displays as PLAY.
    typedef enum logic [2:0] {
        ST_START,
        ST_HELP,
        ST_SELECT,
        ST_PLAY,
        ST_GAP,
        ST_RESULT
    } state_e;

    function automatic page_e page_of(input state_e s);
        case (s)
            ST_START:        return PAGE_START;
            ST_HELP:         return PAGE_HELP;
            ST_SELECT:       return PAGE_SELECT;
            ST_PLAY, ST_GAP: return PAGE_PLAY;
            ST_RESULT:       return PAGE_RESULT;
            default:         return PAGE_START;
        endcase
    endfunction

    // Returns pile idx (pile_w bits wide, zero-extended). Positions beyond the
    // board read as zero, so an out-of-range index yields an empty pile.
    function automatic logic [MAX_PILE_W-1:0] pile_extract(
        input logic [MAX_BOARD_W-1:0] board,
        input int                     idx,
        input int                     pile_w
    );
        logic [MAX_PILE_W-1:0] pile;
        int                    pos;
        pile = '0;
        for (int b = 0; b < MAX_PILE_W; b++) begin
            pos = idx * pile_w + b;
            if (b < pile_w && pos >= 0 && pos < MAX_BOARD_W) begin
                pile[b] = board[pos[MAX_BOARD_AW-1:0]];
            end
        end
        return pile;
    endfunction

endpackage

// File: rtl/nim_game_sequencer_if.sv
// -----------------------------------------------------------------------------
// nim_game_sequencer_if
// Bundles the sequencer's key/move inputs and board/status outputs.
//   master : upstream side (key decoder, selector) drives keys and moves,
//            observes board and status
//   slave  : the sequencer itself
// Signals:
//   key_enter/key_space/key_esc  1-cycle key pulses
//   rounds_sel                   rounds needed to win the match
//   init_board                   starting board for every round
//   move_valid/index/value       move request from the current player
//   board, page, player          current board, screen and turn owner
//   score0/score1, winner        match status
//   move_reject, timeout         1-cycle event pulses
// -----------------------------------------------------------------------------
interface nim_game_sequencer_if
    import nim_pkg::*;
#(
    parameter int NUM_PILES = NUM_PILES_DEF,
    parameter int PILE_W    = PILE_W_DEF
);
    logic                          key_enter;
    logic                          key_space;
    logic                          key_esc;
    logic [STATUS_W-1:0]           rounds_sel;
    logic [NUM_PILES*PILE_W-1:0]   init_board;
    logic                          move_valid;
    logic [3:0]                    move_index;
    logic [PILE_W-1:0]             move_value;

    logic [NUM_PILES*PILE_W-1:0]   board;
    page_e                         page;
    logic                          player;
    logic [STATUS_W-1:0]           score0;
    logic [STATUS_W-1:0]           score1;
    logic                          winner;
    logic                          move_reject;
    logic                          timeout;

    modport master (
        output key_enter, key_space, key_esc, rounds_sel, init_board,
               move_valid, move_index, move_value,
        input  board, page, player, score0, score1, winner, move_reject, timeout
    );

    modport slave (
        input  key_enter, key_space, key_esc, rounds_sel, init_board,
               move_valid, move_index, move_value,
        output board, page, player, score0, score1, winner, move_reject, timeout
    );
endinterface

// File: rtl/nim_move_check.sv
// -----------------------------------------------------------------------------
// nim_move_check
// Combinational legality check and board update for one move.
// Ports:
//   i_board          current packed board
//   i_index          pile index of the move
//   i_value          requested new value for that pile
//   o_legal          index in range and value strictly below the pile
//   o_next_board     board with the pile replaced (unchanged if index out of range)
//   o_next_all_zero  o_next_board is empty
// -----------------------------------------------------------------------------
module nim_move_check
    import nim_pkg::*;
#(
    parameter int NUM_PILES = NUM_PILES_DEF,
    parameter int PILE_W    = PILE_W_DEF
) (
    input  logic [NUM_PILES*PILE_W-1:0] i_board,
    input  logic [3:0]                  i_index,
    input  logic [PILE_W-1:0]           i_value,
    output logic                        o_legal,
    output logic [NUM_PILES*PILE_W-1:0] o_next_board,
    output logic                        o_next_all_zero
);
    logic [MAX_BOARD_W-1:0] w_board_ext;
    logic [MAX_PILE_W-1:0]  w_pile;
    logic [31:0]            w_index_ext;
    logic                   w_in_range;

    assign w_board_ext = MAX_BOARD_W'(i_board);
    assign w_index_ext = {28'd0, i_index};
    assign w_in_range  = (w_index_ext < 32'(NUM_PILES));
    assign w_pile      = pile_extract(w_board_ext, int'(w_index_ext), PILE_W);

    // Strictly-less also makes an empty pile illegal: nothing is below zero.
    assign o_legal = w_in_range && (MAX_PILE_W'(i_value) < w_pile);

    // NOTE: every variable written here gets its default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        o_next_board = i_board;
        for (int p = 0; p < NUM_PILES; p++) begin
            if (w_index_ext == 32'(p)) begin
                o_next_board[p*PILE_W +: PILE_W] = i_value;
            end
        end
    end

    assign o_next_all_zero = (o_next_board == '0);

endmodule

// File: rtl/nim_game_sequencer.sv
// -----------------------------------------------------------------------------
// nim_game_sequencer
// Screen flow, turn ownership, move application, round scoring and match end
// for the two-player pile game. Sole writer of the board register.
// Ports:
//   clk   system clock
//   rst   synchronous, active-high reset
//   bus   nim_game_sequencer_if.slave: key pulses, round setup and moves in;
//         board, page, player, scores, winner, move_reject, timeout out
// Build option:
//   NIM_TURN_TIMEOUT_EN  when defined, adds parameter TIMEOUT_CYC and a per-turn
//                        counter that passes the turn on expiry; otherwise no
//                        counter exists and timeout is always 0.
// -----------------------------------------------------------------------------
module nim_game_sequencer
    import nim_pkg::*;
#(
    parameter int NUM_PILES   = NUM_PILES_DEF,
    parameter int PILE_W      = PILE_W_DEF
`ifdef NIM_TURN_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 500_000_000
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    nim_game_sequencer_if.slave   bus
);
    localparam int BOARD_W = NUM_PILES * PILE_W;

    state_e              r_state,   w_state_nxt;
    logic [BOARD_W-1:0]  r_board,   w_board_nxt;
    logic                r_player,  w_player_nxt;
    logic [STATUS_W-1:0] r_score0,  w_score0_nxt;
    logic [STATUS_W-1:0] r_score1,  w_score1_nxt;
    logic                r_winner,  w_winner_nxt;
    logic [STATUS_W-1:0] r_target,  w_target_nxt;
    logic                r_reject,  w_reject_nxt;
    logic                r_timeout, w_timeout_nxt;

    logic                w_legal;
    logic [BOARD_W-1:0]  w_next_board;
    logic                w_next_all_zero;
    logic [STATUS_W-1:0] w_mover_score;
    logic [STATUS_W-1:0] w_mover_score_inc;
    logic                w_expire;

    nim_move_check #(
        .NUM_PILES (NUM_PILES),
        .PILE_W    (PILE_W)
    ) u_move_check (
        .i_board         (r_board),
        .i_index         (bus.move_index),
        .i_value         (bus.move_value),
        .o_legal         (w_legal),
        .o_next_board    (w_next_board),
        .o_next_all_zero (w_next_all_zero)
    );

    // Score of the player making the move, incremented with saturation at 7.
    assign w_mover_score     = r_player ? r_score1 : r_score0;
    assign w_mover_score_inc = (w_mover_score == '1) ? w_mover_score
                                                     : w_mover_score + STATUS_W'(1);

`ifdef NIM_TURN_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;

    logic [CNT_W-1:0] r_turn_cnt;
    logic             w_turn_change;

    assign w_turn_change = (w_player_nxt != r_player);

    // Counts only while a turn is live; GAP and every other page hold it at
    // zero, which also covers the clear on entry to PLAY.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_turn_cnt <= '0;
        end else if (r_state != ST_PLAY || w_turn_change) begin
            r_turn_cnt <= '0;
        end else begin
            r_turn_cnt <= r_turn_cnt + CNT_W'(1);
        end
    end

    assign w_expire = (r_state == ST_PLAY) && (r_turn_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    assign w_expire = 1'b0;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_board_nxt   = r_board;
        w_player_nxt  = r_player;
        w_score0_nxt  = r_score0;
        w_score1_nxt  = r_score1;
        w_winner_nxt  = r_winner;
        w_target_nxt  = r_target;
        w_reject_nxt  = 1'b0;
        w_timeout_nxt = 1'b0;

        case (r_state)
            ST_START: begin
                // Enter is tested first so it wins over a simultaneous space.
                if (bus.key_enter) begin
                    w_state_nxt = ST_SELECT;
                end else if (bus.key_space) begin
                    w_state_nxt = ST_HELP;
                end
            end

            ST_HELP: begin
                if (bus.key_esc) begin
                    w_state_nxt = ST_START;
                end else if (bus.key_enter) begin
                    w_state_nxt = ST_SELECT;
                end
            end

            ST_SELECT: begin
                if (bus.key_esc) begin
                    w_state_nxt = ST_START;
                end else if (bus.key_enter && bus.rounds_sel != '0) begin
                    w_state_nxt  = ST_PLAY;
                    w_target_nxt = bus.rounds_sel;
                    w_board_nxt  = bus.init_board;
                    w_score0_nxt = '0;
                    w_score1_nxt = '0;
                    w_player_nxt = 1'b0;
                end
            end

            ST_PLAY: begin
                if (bus.key_esc) begin
                    // Abort drops the match; the pending move is discarded.
                    w_state_nxt  = ST_START;
                    w_score0_nxt = '0;
                    w_score1_nxt = '0;
                end else if (bus.move_valid && w_legal) begin
                    w_board_nxt = w_next_board;
                    if (!w_next_all_zero) begin
                        w_player_nxt = ~r_player;
                    end else begin
                        if (r_player) begin
                            w_score1_nxt = w_mover_score_inc;
                        end else begin
                            w_score0_nxt = w_mover_score_inc;
                        end
                        if (w_mover_score_inc == r_target) begin
                            w_state_nxt  = ST_RESULT;
                            w_winner_nxt = r_player;
                        end else begin
                            w_state_nxt = ST_GAP;
                        end
                    end
                end else begin
                    // A legal move on the expiry cycle takes the branch above,
                    // so expiry only acts when no move was applied.
                    w_reject_nxt = bus.move_valid;
                    if (w_expire) begin
                        w_player_nxt  = ~r_player;
                        w_timeout_nxt = 1'b1;
                    end
                end
            end

            ST_GAP: begin
                // Player still holds the round winner here; the loser opens.
                w_state_nxt  = ST_PLAY;
                w_board_nxt  = bus.init_board;
                w_player_nxt = ~r_player;
                w_reject_nxt = bus.move_valid;
            end

            ST_RESULT: begin
                if (bus.key_enter) begin
                    w_state_nxt = ST_START;
                end
            end

            default: begin
                w_state_nxt = ST_START;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_START;
            r_board   <= '0;
            r_player  <= 1'b0;
            r_score0  <= '0;
            r_score1  <= '0;
            r_winner  <= 1'b0;
            r_target  <= '0;
            r_reject  <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_board   <= w_board_nxt;
            r_player  <= w_player_nxt;
            r_score0  <= w_score0_nxt;
            r_score1  <= w_score1_nxt;
            r_winner  <= w_winner_nxt;
            r_target  <= w_target_nxt;
            r_reject  <= w_reject_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign bus.board       = r_board;
    assign bus.page        = page_of(r_state);
    assign bus.player      = r_player;
    assign bus.score0      = r_score0;
    assign bus.score1      = r_score1;
    assign bus.winner      = r_winner;
    assign bus.move_reject = r_reject;
    assign bus.timeout     = r_timeout;

endmodule

// File: tb/tb_nim_game_sequencer.sv
// -----------------------------------------------------------------------------
// tb_nim_game_sequencer
// Directed bench for nim_game_sequencer: screen flow, move legality, round and
// match scoring, esc priority, mid-game reset and the optional turn timeout
// (NIM_TURN_TIMEOUT_EN, with TIMEOUT_CYC=8).
// -----------------------------------------------------------------------------
module tb_nim_game_sequencer;
    import nim_pkg::*;

    localparam int NP = 10;
    localparam int PW = 4;
    localparam int BW = NP * PW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    nim_game_sequencer_if #(.NUM_PILES(NP), .PILE_W(PW)) bus ();

    nim_game_sequencer #(
        .NUM_PILES   (NP),
        .PILE_W      (PW)
`ifdef NIM_TURN_TIMEOUT_EN
        ,
        .TIMEOUT_CYC (8)
`endif
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Inputs change 1 time unit after the rising edge; outputs are read there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic enter, input logic space, input logic esc);
        bus.key_enter = enter;
        bus.key_space = space;
        bus.key_esc   = esc;
        tick();
        bus.key_enter = 1'b0;
        bus.key_space = 1'b0;
        bus.key_esc   = 1'b0;
    endtask

    task automatic do_move(input logic [3:0] idx, input logic [PW-1:0] val);
        bus.move_valid = 1'b1;
        bus.move_index = idx;
        bus.move_value = val;
        tick();
        bus.move_valid = 1'b0;
    endtask

    task automatic start_match(input logic [2:0] rounds, input logic [BW-1:0] init);
        press(1'b1, 1'b0, 1'b0);
        bus.rounds_sel = rounds;
        bus.init_board = init;
        press(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (bus.page !== PAGE_START) begin errors++; $display("FAIL reset_page got %0d exp %0d", bus.page, PAGE_START); end
        checks++; if (bus.board !== '0) begin errors++; $display("FAIL reset_board got %h exp 0", bus.board); end
        checks++; if (bus.player !== 1'b0) begin errors++; $display("FAIL reset_player got %b exp 0", bus.player); end
        checks++; if (bus.score0 !== 3'd0 || bus.score1 !== 3'd0) begin errors++; $display("FAIL reset_scores got %0d/%0d exp 0/0", bus.score0, bus.score1); end
        checks++; if (bus.winner !== 1'b0) begin errors++; $display("FAIL reset_winner got %b exp 0", bus.winner); end
        checks++; if (bus.move_reject !== 1'b0 || bus.timeout !== 1'b0) begin errors++; $display("FAIL reset_pulses got %b%b exp 00", bus.move_reject, bus.timeout); end
    endtask

    task automatic test_screens();
        press(1'b1, 1'b1, 1'b0);
        checks++; if (bus.page !== PAGE_SELECT) begin errors++; $display("FAIL enter_over_space got %0d exp %0d", bus.page, PAGE_SELECT); end
        press(1'b0, 1'b0, 1'b1);
        checks++; if (bus.page !== PAGE_START) begin errors++; $display("FAIL select_esc got %0d exp %0d", bus.page, PAGE_START); end
        press(1'b0, 1'b1, 1'b0);
        checks++; if (bus.page !== PAGE_HELP) begin errors++; $display("FAIL start_space got %0d exp %0d", bus.page, PAGE_HELP); end
        press(1'b0, 1'b0, 1'b1);
        checks++; if (bus.page !== PAGE_START) begin errors++; $display("FAIL help_esc got %0d exp %0d", bus.page, PAGE_START); end
        press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        checks++; if (bus.page !== PAGE_SELECT) begin errors++; $display("FAIL help_enter got %0d exp %0d", bus.page, PAGE_SELECT); end
        bus.rounds_sel = 3'd0;
        press(1'b1, 1'b0, 1'b0);
        checks++; if (bus.page !== PAGE_SELECT) begin errors++; $display("FAIL rounds_zero got %0d exp %0d", bus.page, PAGE_SELECT); end
        bus.init_board = 40'h0000000003;
        do_move(4'd0, 4'd1);
        checks++; if (bus.move_reject !== 1'b0 || bus.board !== '0) begin errors++; $display("FAIL move_outside_play got rej=%b board=%h exp rej=0 board=0", bus.move_reject, bus.board); end
    endtask

    task automatic test_start_round();
        bus.rounds_sel = 3'd1;
        bus.init_board = 40'h0000000003;
        press(1'b1, 1'b0, 1'b0);
        checks++; if (bus.page !== PAGE_PLAY) begin errors++; $display("FAIL start_page got %0d exp %0d", bus.page, PAGE_PLAY); end
        checks++; if (bus.board !== 40'h0000000003) begin errors++; $display("FAIL start_board got %h exp 0000000003", bus.board); end
        checks++; if (bus.player !== 1'b0 || bus.score0 !== 3'd0 || bus.score1 !== 3'd0) begin errors++; $display("FAIL start_status got p=%b s=%0d/%0d exp p=0 s=0/0", bus.player, bus.score0, bus.score1); end
    endtask

    task automatic test_move_legality();
        do_move(4'd0, 4'd1);
        checks++; if (bus.board !== 40'h0000000001 || bus.player !== 1'b1 || bus.move_reject !== 1'b0) begin errors++; $display("FAIL legal_move got board=%h p=%b rej=%b exp 0000000001 1 0", bus.board, bus.player, bus.move_reject); end
        do_move(4'd0, 4'd1);
        checks++; if (bus.move_reject !== 1'b1 || bus.board !== 40'h0000000001 || bus.player !== 1'b1) begin errors++; $display("FAIL equal_value got rej=%b board=%h p=%b exp 1 0000000001 1", bus.move_reject, bus.board, bus.player); end
        tick();
        checks++; if (bus.move_reject !== 1'b0) begin errors++; $display("FAIL reject_pulse got %b exp 0", bus.move_reject); end
        do_move(4'd10, 4'd0);
        checks++; if (bus.move_reject !== 1'b1 || bus.board !== 40'h0000000001) begin errors++; $display("FAIL index_range got rej=%b board=%h exp 1 0000000001", bus.move_reject, bus.board); end
        do_move(4'd3, 4'd0);
        checks++; if (bus.move_reject !== 1'b1 || bus.player !== 1'b1) begin errors++; $display("FAIL empty_pile got rej=%b p=%b exp 1 1", bus.move_reject, bus.player); end
        // Player 1 empties the board; target is 1, so the match ends.
        do_move(4'd0, 4'd0);
        checks++; if (bus.page !== PAGE_RESULT || bus.winner !== 1'b1 || bus.score1 !== 3'd1 || bus.score0 !== 3'd0) begin errors++; $display("FAIL p1_match got page=%0d w=%b s=%0d/%0d exp 4 1 0/1", bus.page, bus.winner, bus.score0, bus.score1); end
        press(1'b0, 1'b1, 1'b1);
        checks++; if (bus.page !== PAGE_RESULT) begin errors++; $display("FAIL result_ignores got %0d exp %0d", bus.page, PAGE_RESULT); end
        press(1'b1, 1'b0, 1'b0);
        checks++; if (bus.page !== PAGE_START) begin errors++; $display("FAIL result_enter got %0d exp %0d", bus.page, PAGE_START); end
    endtask

    task automatic test_rounds();
        start_match(3'd2, 40'h0000000003);
        do_move(4'd0, 4'd0);
        checks++; if (bus.score0 !== 3'd1 || bus.board !== '0 || bus.page !== PAGE_PLAY || bus.player !== 1'b0) begin errors++; $display("FAIL round_win got s0=%0d board=%h page=%0d p=%b exp 1 0 3 0", bus.score0, bus.board, bus.page, bus.player); end
        // This request lands in the GAP cycle.
        do_move(4'd0, 4'd0);
        checks++; if (bus.move_reject !== 1'b1 || bus.board !== 40'h0000000003 || bus.player !== 1'b1) begin errors++; $display("FAIL gap_reload got rej=%b board=%h p=%b exp 1 0000000003 1", bus.move_reject, bus.board, bus.player); end
        do_move(4'd0, 4'd1);
        checks++; if (bus.board !== 40'h0000000001 || bus.player !== 1'b0) begin errors++; $display("FAIL round2_move got board=%h p=%b exp 0000000001 0", bus.board, bus.player); end
        do_move(4'd0, 4'd0);
        checks++; if (bus.page !== PAGE_RESULT || bus.winner !== 1'b0 || bus.score0 !== 3'd2) begin errors++; $display("FAIL p0_match got page=%0d w=%b s0=%0d exp 4 0 2", bus.page, bus.winner, bus.score0); end
        press(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_esc_priority();
        start_match(3'd3, 40'h0000000003);
        do_move(4'd0, 4'd0);
        tick();
        checks++; if (bus.score0 !== 3'd1 || bus.player !== 1'b1 || bus.board !== 40'h0000000003) begin errors++; $display("FAIL esc_setup got s0=%0d p=%b board=%h exp 1 1 0000000003", bus.score0, bus.player, bus.board); end
        bus.key_esc = 1'b1;
        do_move(4'd0, 4'd1);
        bus.key_esc = 1'b0;
        checks++; if (bus.page !== PAGE_START || bus.score0 !== 3'd0 || bus.score1 !== 3'd0) begin errors++; $display("FAIL esc_abort got page=%0d s=%0d/%0d exp 0 0/0", bus.page, bus.score0, bus.score1); end
        checks++; if (bus.board !== 40'h0000000003 || bus.move_reject !== 1'b0) begin errors++; $display("FAIL esc_board got board=%h rej=%b exp 0000000003 0", bus.board, bus.move_reject); end
    endtask

    task automatic test_reset_mid_play();
        start_match(3'd3, 40'h0000000001);
        do_move(4'd0, 4'd0); tick();
        do_move(4'd0, 4'd0); tick();
        do_move(4'd0, 4'd0); tick();
        do_move(4'd0, 4'd0); tick();
        checks++; if (bus.score0 !== 3'd2 || bus.score1 !== 3'd2 || bus.page !== PAGE_PLAY || bus.player !== 1'b0) begin errors++; $display("FAIL pre_reset got s=%0d/%0d page=%0d p=%b exp 2/2 3 0", bus.score0, bus.score1, bus.page, bus.player); end
        rst = 1'b1;
        do_move(4'd10, 4'd0);
        rst = 1'b0;
        checks++; if (bus.page !== PAGE_START || bus.board !== '0 || bus.player !== 1'b0) begin errors++; $display("FAIL mid_reset_state got page=%0d board=%h p=%b exp 0 0 0", bus.page, bus.board, bus.player); end
        checks++; if (bus.score0 !== 3'd0 || bus.score1 !== 3'd0 || bus.winner !== 1'b0 || bus.move_reject !== 1'b0 || bus.timeout !== 1'b0) begin errors++; $display("FAIL mid_reset_status got s=%0d/%0d w=%b rej=%b to=%b exp all 0", bus.score0, bus.score1, bus.winner, bus.move_reject, bus.timeout); end
    endtask

    task automatic test_timeout();
        start_match(3'd1, 40'h0000000003);
`ifdef NIM_TURN_TIMEOUT_EN
        repeat (7) tick();
        checks++; if (bus.timeout !== 1'b0 || bus.player !== 1'b0) begin errors++; $display("FAIL to_early got to=%b p=%b exp 0 0", bus.timeout, bus.player); end
        tick();
        checks++; if (bus.timeout !== 1'b1 || bus.player !== 1'b1 || bus.board !== 40'h0000000003) begin errors++; $display("FAIL to_fire got to=%b p=%b board=%h exp 1 1 0000000003", bus.timeout, bus.player, bus.board); end
        tick();
        checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL to_pulse got %b exp 0", bus.timeout); end
        // Six more edges bring the counter back to its last value.
        repeat (6) tick();
        do_move(4'd0, 4'd2);
        checks++; if (bus.timeout !== 1'b0 || bus.board !== 40'h0000000002 || bus.player !== 1'b0) begin errors++; $display("FAIL to_move_wins got to=%b board=%h p=%b exp 0 0000000002 0", bus.timeout, bus.board, bus.player); end
`else
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++; if (bus.timeout !== 1'b0 || bus.player !== 1'b0) begin errors++; $display("FAIL to_disabled cycle %0d got to=%b p=%b exp 0 0", i, bus.timeout, bus.player); end
        end
`endif
    endtask

    initial begin
        bus.key_enter  = 1'b0;
        bus.key_space  = 1'b0;
        bus.key_esc    = 1'b0;
        bus.rounds_sel = 3'd0;
        bus.init_board = '0;
        bus.move_valid = 1'b0;
        bus.move_index = 4'd0;
        bus.move_value = '0;

        test_reset();
        test_screens();
        test_start_round();
        test_move_legality();
        test_rounds();
        test_esc_priority();
        test_reset_mid_play();
        test_reset();
        test_timeout();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got time limit exp bench completion");
        $fatal(1, "time limit reached");
    end

endmodule
